// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 8-digit scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high here.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  typedef logic [IDX_W-1:0] digit_idx_t;
  typedef logic [3:0]       nibble_t;
  typedef logic [6:0]       seg_t;

  // Digits 4 and 6 carry the decimal point as a separator between fields.
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 8'b0101_0000;

  // One coherent capture of everything the display shows during a frame.
  typedef struct packed {
    logic [4:0]  opc;
    logic [4:0]  pc;
    logic [15:0] rd;
  } snap_t;

  function automatic seg_t hex7(input nibble_t n);
    seg_t s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to seven-segment decoder (active-high {g,f,e,d,c,b,a}).
// Polarity inversion for the board is done by the caller at the output register.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes the core's read_data / PC / opcode onto an 8-digit seven-segment
// display, one digit per slot, with a tear-free per-frame snapshot and inter-digit blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] read_data,
  input  logic [4:0]  PC_out,
  input  logic [4:0]  opcode_out,
  input  logic        hold,
  input  logic [7:0]  blank_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_tick
);

  if (BLANK_CYCLES >= REFRESH_DIV || REFRESH_DIV < 4) begin : g_bad_params
    $error("seg7_scan_driver: need REFRESH_DIV >= 4 and BLANK_CYCLES < REFRESH_DIV");
  end

  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYCLES);
  localparam digit_idx_t       IDX_LAST    = digit_idx_t'(NUM_DIGITS - 1);

  // XOR masks turn active-high internal values into board polarity; they are
  // also the "all off" values because 0 ^ mask == mask.
  localparam logic [7:0] AN_POL  = {8{AN_ACT_LOW}};
  localparam logic [6:0] SEG_POL = {7{SEG_ACT_LOW}};
  localparam logic       DP_POL  = SEG_ACT_LOW;

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  snap_t            snap;

  logic    slot_end;
  logic    frame_end;
  logic    lit;
  nibble_t digit;
  seg_t    seg_hi;
  logic [7:0] an_hi;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Prescaler, digit index, snapshot
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The snapshot is a small register, not a memory, so it is reset: the first
  // frame after reset must show zeros rather than whatever powered up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end && !hold;
      if (frame_end && !hold) begin
        snap <= '{opc: opcode_out, pc: PC_out, rd: read_data};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and decode
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first means every path writes digit, so no
  // latch is inferred even if the case is later edited to be incomplete.
  always_comb begin
    digit = '0;
    unique case (idx)
      3'd0: digit = snap.rd[3:0];
      3'd1: digit = snap.rd[7:4];
      3'd2: digit = snap.rd[11:8];
      3'd3: digit = snap.rd[15:12];
      3'd4: digit = snap.pc[3:0];
      3'd5: digit = {3'b000, snap.pc[4]};
      3'd6: digit = snap.opc[3:0];
      3'd7: digit = {3'b000, snap.opc[4]};
      default: digit = '0;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (digit),
    .seg    (seg_hi)
  );

  assign lit   = (cnt >= BLANK_START) && !blank_mask[idx];
  assign an_hi = 8'b0000_0001 << idx;

  // ---------------------------------------------------------------------------
  // Output registers: one cycle behind cnt/idx, polarity applied last.
  // A single shifted one-hot source guarantees at most one anode is ever on.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= AN_POL;
      seg <= SEG_POL;
      dp  <= DP_POL;
    end else if (lit) begin
      an  <= an_hi ^ AN_POL;
      seg <= seg_hi ^ SEG_POL;
      dp  <= DP_MASK[idx] ^ DP_POL;
    end else begin
      an  <= AN_POL;
      seg <= SEG_POL;
      dp  <= DP_POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (REFRESH_DIV=8, BLANK_CYCLES=2, active-low).
// A cycle-count reference model queues expected outputs; a negedge monitor compares.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] read_data;
  logic [4:0]  PC_out;
  logic [4:0]  opcode_out;
  logic        hold;
  logic [7:0]  blank_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_tick;

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK),
    .SEG_ACT_LOW  (1'b1),
    .AN_ACT_LOW   (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .read_data  (read_data),
    .PC_out     (PC_out),
    .opcode_out (opcode_out),
    .hold       (hold),
    .blank_mask (blank_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } obs_t;

  localparam obs_t OFF = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Reference model: display state is a pure function of edges since reset.
  int unsigned m_k;
  logic [15:0] m_rd;
  logic [4:0]  m_pc;
  logic [4:0]  m_opc;
  int          m_pos, m_d;
  logic [3:0]  m_digits [8];
  logic        m_lit;
  obs_t        m_e;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_k = 0;
      m_rd = '0;
      m_pc = '0;
      m_opc = '0;
      exp_q.delete();
    end else begin
      m_pos = int'(m_k % DIV);
      m_d   = int'((m_k / DIV) % 8);
      for (int i = 0; i < 4; i++) m_digits[i] = m_rd[4*i +: 4];
      m_digits[4] = m_pc[3:0];
      m_digits[5] = {3'b000, m_pc[4]};
      m_digits[6] = m_opc[3:0];
      m_digits[7] = {3'b000, m_opc[4]};
      m_lit = (m_pos >= BLANK) && !blank_mask[m_d];
      m_e = OFF;
      if (m_lit) begin
        m_e.an  = ~(8'h01 << m_d);
        m_e.seg = ~hex_tab[m_digits[m_d]];
        m_e.dp  = !(m_d == 4 || m_d == 6);
      end
      if ((m_k % FRAME) == FRAME - 1 && !hold) begin
        m_rd  = read_data;
        m_pc  = PC_out;
        m_opc = opcode_out;
        m_e.tick = 1'b1;
      end
      exp_q.push_back(m_e);
      m_k++;
    end
  end

  // Monitor: pops one expectation per cycle, plus the anode invariant.
  obs_t mon_e;
  always @(negedge clock) begin
    if (reset) begin
      check("reset_outputs", {15'd0, an, seg, dp, frame_tick}, {15'd0, OFF});
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("scan_outputs", {15'd0, an, seg, dp, frame_tick}, {15'd0, mon_e});
    end
    check("anode_onehot_or_none", 32'($countones(~an) <= 1), 32'd1);
  end

  task automatic wait_an(input logic [7:0] want, input int lim, input string name);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clock);
      if (an == want) ok = 1;
    end
    if (!ok) check({name, "_timeout"}, {24'd0, an}, {24'd0, want});
  endtask

  task automatic wait_tick(input int lim, input string name);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clock);
      if (frame_tick) ok = 1;
    end
    if (!ok) check({name, "_timeout"}, 32'(frame_tick), 32'd1);
  endtask

  int ticks;
  int low_lo;
  int d4_lit;

  initial begin
    read_data  = '0;
    PC_out     = '0;
    opcode_out = '0;
    hold       = 1'b0;
    blank_mask = '0;

    // 1. Reset state and first lit slot
    repeat (3) @(negedge clock);
    check("reset_an", {24'd0, an}, 32'hFF);
    check("reset_seg", {25'd0, seg}, 32'h7F);
    check("reset_dp", 32'(dp), 32'd1);
    reset = 1'b0;
    wait_an(8'hFE, 3 * DIV, "first_lit");
    check("first_digit_seg", {25'd0, seg}, 32'h40);

    // 2. Known pattern captured at the next frame boundary
    read_data  = 16'hA5F1;
    PC_out     = 5'h13;
    opcode_out = 5'h0C;
    wait_tick(FRAME + 4, "tick_a5f1");
    wait_an(8'hFE, 2 * DIV, "d0_a5f1");
    check("d0_seg_1", {25'd0, seg}, 32'h79);
    wait_an(8'hF7, 4 * DIV, "d3_a5f1");
    check("d3_seg_A", {25'd0, seg}, 32'h08);

    // 3. Three frames of free scanning under the monitor
    repeat (3 * FRAME) @(negedge clock);

    // 4. Hold freezes the snapshot and suppresses frame_tick
    hold = 1'b1;
    read_data = 16'h0000;
    ticks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clock);
      if (frame_tick) ticks++;
    end
    check("hold_no_tick", 32'(ticks), 32'd0);
    wait_an(8'hFE, FRAME, "d0_held");
    check("held_d0_seg", {25'd0, seg}, 32'h79);
    hold = 1'b0;
    wait_tick(FRAME + 4, "tick_after_hold");
    wait_an(8'hFE, 2 * DIV, "d0_released");
    check("released_d0_seg", {25'd0, seg}, 32'h40);

    // 5. Live blank mask on the low four digits
    blank_mask = 8'h0F;
    repeat (2) @(negedge clock);
    low_lo = 0;
    d4_lit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clock);
      if (~an[3:0] != 4'h0) low_lo++;
      if (an == 8'hEF) d4_lit++;
    end
    check("masked_digits_dark", 32'(low_lo), 32'd0);
    check("d4_lit_cycles", 32'(d4_lit), 32'(2 * (DIV - BLANK)));
    blank_mask = 8'h00;

    // Randomised inputs, hold and mask; inputs change mid-frame freely
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) begin
        read_data  = 16'($urandom);
        PC_out     = 5'($urandom);
        opcode_out = 5'($urandom);
      end
      if ($urandom_range(0, 31) == 0) hold = 1'($urandom);
      if ($urandom_range(0, 47) == 0) blank_mask = 8'($urandom);
    end
    hold = 1'b0;
    blank_mask = 8'h00;
    repeat (2 * FRAME) @(negedge clock);

    // 6. Asynchronous reset in the middle of digit 5's slot
    wait_an(8'hDF, 2 * FRAME, "d5_lit");
    #1 reset = 1'b1;
    #1;
    check("midslot_reset_an", {24'd0, an}, 32'hFF);
    check("midslot_reset_seg", {25'd0, seg}, 32'h7F);
    check("midslot_reset_dp", 32'(dp), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 2 * DIV && !seen; i++) begin
        @(negedge clock);
        if (an != 8'hFF) seen = 1;
      end
      check("resume_at_d0", {24'd0, an}, 32'hFE);
    end
    repeat (FRAME + 4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
